// File: rtl/bitvec_id_drain_pkg.sv
// Shared parameters and state type for the bit-vector to index drain path.
// Vector sizes match the Cell/ufpu/bfpu result width.
package bitvec_id_drain_pkg;

  localparam int BIT_VEC_SIZE     = 128;
  localparam int BIT_VEC_SIZE_LOG = 7;
  localparam int FIFO_DEPTH       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/bitvec_fifo.sv
// Small synchronous FIFO with a combinational head (no read latency).
// A push while full is accepted only when a pop happens in the same cycle.
module bitvec_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/bitvec_id_drain.sv
// Drains buffered result vectors as a stream of set-bit indices, lowest first,
// one beat per accepted handshake, with last/none markers per vector.
module bitvec_id_drain #(
  parameter int BIT_VEC_SIZE     = bitvec_id_drain_pkg::BIT_VEC_SIZE,
  parameter int BIT_VEC_SIZE_LOG = bitvec_id_drain_pkg::BIT_VEC_SIZE_LOG,
  parameter int FIFO_DEPTH       = bitvec_id_drain_pkg::FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BIT_VEC_SIZE-1:0]     vec_in,
  input  logic                        vec_valid_in,
  output logic [BIT_VEC_SIZE_LOG-1:0] id_out,
  output logic                        id_valid,
  output logic                        id_last,
  output logic                        id_none,
  input  logic                        id_ready,
  output logic                        overflow,
  output logic                        busy
);

  import bitvec_id_drain_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  drain_state_t              r_state;
  drain_state_t              w_state_nxt;
  logic [BIT_VEC_SIZE-1:0]   r_work;
  logic [BIT_VEC_SIZE-1:0]   w_work_nxt;
  logic [BIT_VEC_SIZE-1:0]   w_work_rest;
  logic [BIT_VEC_SIZE-1:0]   w_fifo_dout;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [CNT_W-1:0]          w_fifo_count;
  logic                      w_pop;
  logic                      w_last;
  logic                      w_none;
  logic                      r_overflow;

  function automatic logic [BIT_VEC_SIZE_LOG-1:0] lsb_index(input logic [BIT_VEC_SIZE-1:0] v);
    lsb_index = '0;
    for (int i = BIT_VEC_SIZE - 1; i >= 0; i--) begin
      if (v[i]) lsb_index = i[BIT_VEC_SIZE_LOG-1:0];
    end
  endfunction

  bitvec_fifo #(
    .WIDTH (BIT_VEC_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vec_valid_in),
    .pop   (w_pop),
    .din   (vec_in),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // work with its lowest set bit removed; zero means at most one bit remains
  assign w_work_rest = r_work & (r_work - BIT_VEC_SIZE'(1));
  assign w_last      = (w_work_rest == '0);
  assign w_none      = (r_work == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_work_nxt  = w_fifo_dout;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (id_ready) begin
          if (!w_last) begin
            w_work_nxt = w_work_rest;
          end else if (!w_fifo_empty) begin
            // chain straight into the next vector so beats stay back-to-back
            w_pop      = 1'b1;
            w_work_nxt = w_fifo_dout;
          end else begin
            w_work_nxt  = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_work     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      if (vec_valid_in && w_fifo_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Outputs come from registered state only; id_ready never reaches them.
  assign id_valid = (r_state == SCAN);
  assign id_out   = id_valid ? lsb_index(r_work) : '0;
  assign id_last  = id_valid & w_last;
  assign id_none  = id_valid & w_none;
  assign overflow = r_overflow;
  assign busy     = id_valid | (w_fifo_count != '0);

endmodule

// File: tb/tb_bitvec_id_drain.sv
// Directed and randomized bench for bitvec_id_drain against a beat-queue model.
module tb_bitvec_id_drain;

  localparam int W  = 128;
  localparam int LW = 7;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  vec_in = '0;
  logic          vec_valid_in = 1'b0;
  logic          id_ready = 1'b0;
  logic [LW-1:0] id_out;
  logic          id_valid;
  logic          id_last;
  logic          id_none;
  logic          overflow;
  logic          busy;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  int          pending = 0;
  bit          accept_push = 1'b1;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_beat = '0;
  int          nvec = 0;

  bitvec_id_drain #(
    .BIT_VEC_SIZE     (W),
    .BIT_VEC_SIZE_LOG (LW),
    .FIFO_DEPTH       (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vec_in       (vec_in),
    .vec_valid_in (vec_valid_in),
    .id_out       (id_out),
    .id_valid     (id_valid),
    .id_last      (id_last),
    .id_none      (id_none),
    .id_ready     (id_ready),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] beat(input logic [LW-1:0] id, input logic last, input logic none);
    return {23'd0, none, last, id};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected beats for one vector: ascending set-bit indices, or a single none beat.
  task automatic add_vec(input logic [W-1:0] v);
    int n;
    int k;
    n = $countones(v);
    k = 0;
    if (n == 0) begin
      exp_q.push_back(beat('0, 1'b1, 1'b1));
    end else begin
      for (int i = 0; i < W; i++) begin
        if (v[i]) begin
          k++;
          exp_q.push_back(beat(LW'(i), k == n, 1'b0));
        end
      end
    end
    pending++;
  endtask

  task automatic check_beat();
    logic [31:0] obs;
    logic [31:0] expv;
    obs = beat(id_out, id_last, id_none);
    if (rst) begin
      prev_stall = 1'b0;
      return;
    end
    chk("busy", 32'(busy), 32'(exp_q.size() != 0));
    if (prev_stall) begin
      chk("hold_valid", 32'(id_valid), 32'd1);
      chk("hold_beat", obs, prev_beat);
    end
    if (id_valid && id_ready) begin
      expv = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("beat", obs, expv);
      if (expv != 32'hDEAD_BEEF && expv[LW]) pending--;
    end
    prev_stall = id_valid && !id_ready;
    prev_beat  = obs;
  endtask

  // Called at a negedge with inputs already set; returns at the following negedge.
  task automatic step();
    check_beat();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      pending = 0;
    end else if (vec_valid_in && accept_push) begin
      add_vec(vec_in);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    case ($urandom % 4)
      0: v = '0;
      1: v = W'(1) << ($urandom % W);
      2: v = (W'(1) << ($urandom % W)) | (W'(1) << ($urandom % W)) | (W'(1) << ($urandom % W));
      default: v = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_id", 32'(id_out), 32'd0);
    chk("rst_last", 32'(id_last), 32'd0);
    chk("rst_none", 32'(id_none), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // bits 0 and 2, two-cycle latency
    id_ready = 1'b1;
    vec_in = W'(5);
    vec_valid_in = 1'b1;
    step();
    vec_valid_in = 1'b0;
    chk("lat_e0_valid", 32'(id_valid), 32'd0);
    chk("lat_e0_busy", 32'(busy), 32'd1);
    step();
    chk("lat_e1_valid", 32'(id_valid), 32'd1);
    chk("t1_id0", 32'(id_out), 32'd0);
    chk("t1_last0", 32'(id_last), 32'd0);
    step();
    chk("t1_id2", 32'(id_out), 32'd2);
    chk("t1_last2", 32'(id_last), 32'd1);
    step();
    chk("t1_busy_fall", 32'(busy), 32'd0);

    // all-zero vector
    vec_in = '0;
    vec_valid_in = 1'b1;
    step();
    vec_valid_in = 1'b0;
    step();
    chk("zero_valid", 32'(id_valid), 32'd1);
    chk("zero_none", 32'(id_none), 32'd1);
    chk("zero_last", 32'(id_last), 32'd1);
    chk("zero_id", 32'(id_out), 32'd0);
    step();
    chk("zero_busy", 32'(busy), 32'd0);

    // backpressure on bits 64 and 127
    id_ready = 1'b0;
    vec_in = (W'(1) << 127) | (W'(1) << 64);
    vec_valid_in = 1'b1;
    step();
    vec_valid_in = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_id64", 32'(id_out), 32'd64);
      step();
    end
    id_ready = 1'b1;
    chk("bp_id64_rel", 32'(id_out), 32'd64);
    step();
    chk("bp_id127", 32'(id_out), 32'd127);
    chk("bp_last127", 32'(id_last), 32'd1);
    step();
    chk("bp_busy", 32'(busy), 32'd0);

    // back-to-back one-bit vectors
    id_ready = 1'b1;
    vec_valid_in = 1'b1;
    vec_in = W'(1) << 3;
    step();
    vec_in = W'(1) << 100;
    step();
    chk("b2b_0", 32'(id_valid), 32'd1);
    vec_in = W'(1);
    step();
    chk("b2b_1", 32'(id_valid), 32'd1);
    vec_valid_in = 1'b0;
    step();
    chk("b2b_2", 32'(id_valid), 32'd1);
    step();
    chk("b2b_end", 32'(id_valid), 32'd0);

    // fill: one vector in work, four buffered
    id_ready = 1'b0;
    vec_valid_in = 1'b1;
    vec_in = W'(1) << 5;
    step();
    vec_in = W'(48);
    step();
    vec_in = '0;
    step();
    vec_in = W'(1) << 127;
    step();
    vec_in = W'(129);
    step();
    chk("ovf_after5", 32'(overflow), 32'd0);
    chk("ovf_work_id", 32'(id_out), 32'd5);
    // push while full alongside a final-beat transfer: accepted
    id_ready = 1'b1;
    vec_in = W'(1) << 99;
    step();
    chk("ovf_pop_push", 32'(overflow), 32'd0);
    // push while full without a pop: dropped
    id_ready = 1'b0;
    vec_in = W'(1) << 77;
    accept_push = 1'b0;
    step();
    accept_push = 1'b1;
    vec_valid_in = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    id_ready = 1'b1;
    drain(200);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // reset in the middle of scanning 0xFF
    vec_in = W'(8'hFF);
    vec_valid_in = 1'b1;
    step();
    vec_valid_in = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("msr_valid", 32'(id_valid), 32'd0);
    chk("msr_busy", 32'(busy), 32'd0);
    chk("msr_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("msr_stale", 32'(id_valid), 32'd0);
    end

    // randomized traffic and backpressure
    for (int cyc = 0; cyc < 4000; cyc++) begin
      id_ready = ($urandom % 4) != 0;
      if (pending < D && nvec < 150 && ($urandom % 3) == 0) begin
        vec_in = rand_vec();
        vec_valid_in = 1'b1;
        nvec++;
      end else begin
        vec_valid_in = 1'b0;
      end
      step();
    end
    vec_valid_in = 1'b0;
    id_ready = 1'b1;
    drain(4000);
    chk("rand_ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitvec_id_drain.md
# bitvec_id_drain

Downstream of the `Cell` pair of BFPU outputs, this block converts each result bit vector (one bit per entry) into a stream of entry indices for the host/output path. Each `vec_valid_in` pulse pushes a full vector into a small FIFO. A scan FSM then emits one set-bit index per accepted beat, lowest index first, with a `last` marker. The FIFO absorbs the BFPU output because that output has no backpressure.

## Interface
- `BIT_VEC_SIZE`, default 128: result vector width.
- `BIT_VEC_SIZE_LOG`, default 7: index width, equal to clog2(BIT_VEC_SIZE).
- `FIFO_DEPTH`, default 4: number of vectors buffered; must be a power of two, at least 2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `vec_in` in BIT_VEC_SIZE: result vector from a BFPU.
- `vec_valid_in` in 1: `vec_in` is valid this cycle. There is no ready.
- `id_out` out BIT_VEC_SIZE_LOG: index of the current set bit.
- `id_valid` out 1: output beat valid.
- `id_last` out 1: final beat of the current vector.
- `id_none` out 1: the current vector was all-zero. The beat carries no index.
- `id_ready` in 1: downstream accepts the beat.
- `overflow` out 1: sticky; a vector was dropped.
- `busy` out 1: FIFO non-empty or FSM in SCAN.

## Operation
**FIFO**
- Writes when `vec_valid_in` is high.
- If the FIFO is full and no pop happens in the same cycle, the vector is dropped and `overflow` is set. `overflow` clears only on `rst`.
- A write and a pop in the same cycle while full: both happen, and occupancy is unchanged.

**FSM states**
- IDLE:
  - If the FIFO is non-empty, pop the head into `work` (BIT_VEC_SIZE bits) and go to SCAN.
  - Otherwise stay in IDLE.
- SCAN:
  - `id_valid` is 1.
  - `id_out` is the lowest set bit of `work`, from a priority encoder.
  - `id_last` is 1 when `work` has at most one set bit.
  - `id_none` is 1 when `work` is 0. In that case `id_out` is 0 and `id_last` is 1.

**Beat transfer**
- A beat transfers when `id_valid` and `id_ready` are both 1.
- On transfer with `id_last`=0, clear the lowest set bit of `work` (work & (work-1)).
- On transfer with `id_last`=1:
  - If the FIFO is non-empty, pop the next vector into `work` the same cycle and stay in SCAN (no bubble).
  - Otherwise go to IDLE.

**Output hold rule**
- While `id_valid`=1 and `id_ready`=0, `id_out`, `id_last` and `id_none` hold stable.
- `id_valid` never drops without a transfer, except on `rst`.

**Derived outputs**
- `busy` = (state==SCAN) | ~fifo_empty.

## Timing
- **Reset:** `rst` forces, on the next edge:
  - state=IDLE, `work`=0, and the FIFO pointers and count to 0;
  - `overflow`=0, `id_valid`=0, `id_last`=0, `id_none`=0, `id_out`=0, `busy`=0.
- **Mid-operation reset:** in-flight and buffered vectors are discarded.
- **Latency:** a vector sampled at edge E, with the FIFO empty and state IDLE:
  - edge E+1 pops it;
  - the first beat is valid in the cycle after E+1, i.e. 2 cycles after input.
- **Throughput:** a vector with n≥1 set bits takes n beats; an all-zero vector takes 1 beat. Under continuous `id_ready`, beats are back-to-back across vectors.
- **FIFO occupancy:** width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- **Combinational paths:** `id_*` outputs depend only on `work` and state; there is no combinational path from `id_ready`.

## Structure
- **Shared package:** BIT_VEC_SIZE and BIT_VEC_SIZE_LOG come from the shared param package (same values as `Cell`/`ufpu`/`bfpu`). Also add a `drain_state_t` enum {IDLE, SCAN} there.
- **Sub-module `bitvec_fifo`:**
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - dout shows the head with no read latency.
- **Top level:** the priority encoder is a function or always_comb loop in the top module; the FSM and `work` register are also in the top.

## Test plan
- **Reset:** hold `rst` for 2 cycles, then push vector 0x...0005 (bits 0, 2) with `id_ready`=1.
  - Beats are id 0 (last=0), then id 2 (last=1), first beat 2 cycles after the push.
  - `busy` falls after the second beat.
- **All-zero vector:** push 0.
  - One beat: `id_none`=1, `id_last`=1, `id_out`=0.
- **Backpressure:** push a vector with bits 127 and 64; hold `id_ready`=0 for 5 cycles, then 1.
  - id 64 is held stable for all 5 cycles, then 64 and 127 transfer.
- **Back-to-back vectors:** push 3 vectors of 1 bit each in consecutive cycles with `id_ready`=1.
  - 3 beats in 3 consecutive cycles, each with `id_last`=1.
- **Overflow:** `id_ready`=0, push 5 vectors with FIFO_DEPTH=4.
  - First vector moves to `work`, 4 are buffered, no overflow.
  - A 6th push sets `overflow`=1 and its data never appears.
  - Push while full in the same cycle as a final-beat transfer: accepted, `overflow` unchanged.
- **Mid-scan reset:** assert `rst` mid-scan of 0xFF.
  - Next cycle: `id_valid`=0, `busy`=0, and no stale ids after release.
